phy_link_seq: RTL
=================

# phy_link_seq

PHY bring-up and link supervision controller for the UDP receive path. Holds the external PHY in reset for a programmed time, then waits a settle time, then qualifies the asynchronous PHY link-status pin. The pin passes through a two-flop synchronizer and must be stable for a programmed number of cycles. Only then does the block enable the receive datapath. It sits between the board-level PHY pins and the frame parser, and gates the parser's receive enable.

## Interface
- RST_HOLD_CYC, default 1000: cycles phy_rst_n_o is held low; must be ≥1.
- SETTLE_CYC, default 5000: cycles after PHY reset release before link is sampled; must be ≥1.
- STABLE_CYC, default 256: consecutive cycles link must be up (or down) to change state; must be ≥1.
- CNT_W, default $clog2(max(RST_HOLD_CYC,SETTLE_CYC,STABLE_CYC)+1): internal counter width; derived, not overridden.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- link_async  in  1  PHY link status, asynchronous to clk, active high.
- restart_i  in  1  synchronous single-cycle request to re-run the full sequence.
- phy_rst_n_o  out  1  PHY reset, active low.
- rx_en_o  out  1  receive-datapath enable.
- link_up_o  out  1  qualified link status.
- link_drops_o  out  8  saturating count of qualified link losses.
- state_o  out  2  current FSM state, for debug.

## Operation
- link_async is synchronized to link_sync by a sync_ff instance with INIT=0. Only link_sync is used internally.
- FSM states: HOLD=0, SETTLE=1, WAIT_LINK=2, RUN=3.
  - HOLD → SETTLE when cnt == RST_HOLD_CYC-1; cnt cleared.
  - SETTLE → WAIT_LINK when cnt == SETTLE_CYC-1; cnt cleared.
  - WAIT_LINK: cnt increments while link_sync=1 and clears to 0 whenever link_sync=0. → RUN on the edge where the increment reaches STABLE_CYC.
  - RUN: cnt increments while link_sync=0 and clears whenever link_sync=1. → WAIT_LINK on the edge where the increment reaches STABLE_CYC. That edge also increments link_drops_o, which saturates at 255.
- restart_i=1 in any state has priority: next state is HOLD, cnt is cleared, and link_drops_o is unchanged.
- Outputs are registered and decoded from the next state, so they change on the same edge as state_o.
  - phy_rst_n_o = 0 in HOLD, 1 otherwise.
  - rx_en_o = link_up_o = 1 only in RUN.
- Reset values (rst_n low, asynchronous):
  - state HOLD, cnt 0.
  - phy_rst_n_o=0, rx_en_o=0, link_up_o=0.
  - link_drops_o=0, state_o=0.
  - Synchronizer flops 0.
- Mid-operation reset forces the reset values immediately, without waiting for a clock edge. The sequence restarts from HOLD.

## Timing
- Synchronizer latency: a link_async change is visible in link_sync after 2 clk edges.
- Numbering: E1 is the first rising edge after rst_n deasserts.
- phy_rst_n_o rises at E(RST_HOLD_CYC).
- WAIT_LINK is entered at E(RST_HOLD_CYC+SETTLE_CYC).
- Minimum time to rx_en_o=1, with link_sync already high: E(RST_HOLD_CYC+SETTLE_CYC+STABLE_CYC).
- Loss detection: rx_en_o falls exactly STABLE_CYC edges after the first low link_sync sample in RUN.
- restart_i sampled at edge En: phy_rst_n_o=0 and rx_en_o=0 from En. phy_rst_n_o rises again at E(n+RST_HOLD_CYC).
- restart_i held high for multiple cycles: the block stays in HOLD with cnt=0. Counting starts after restart_i deasserts.

## Structure
- Package phy_link_seq_pkg holds:
  - typedef enum logic [1:0] state_t with HOLD/SETTLE/WAIT_LINK/RUN and the fixed encodings above;
  - localparam LINK_DROPS_MAX=8'd255.
- One sub-module: sync_ff (INIT=1'b0) for link_async. All other logic is a single FSM plus one shared counter plus the drop counter.

## Test plan
All scenarios use RST_HOLD_CYC=4, SETTLE_CYC=3, STABLE_CYC=2.
- Link high throughout reset, then rst_n released → phy_rst_n_o rises at E4, state_o=2 at E7, rx_en_o=link_up_o=1 at E9.
- In WAIT_LINK, link_async pulsed high for 1 cycle (link_sync high for 1 cycle) → state stays WAIT_LINK, rx_en_o stays 0.
- In RUN, link_sync low for 1 cycle → stays RUN. In RUN, link_sync low for 2 cycles → state_o=2, rx_en_o=0, link_drops_o=1.
- restart_i pulsed at En while in RUN → phy_rst_n_o=0 at En, phy_rst_n_o=1 at E(n+4), link_drops_o unchanged.
- rst_n asserted mid-SETTLE → asynchronously phy_rst_n_o=0, rx_en_o=0, link_drops_o=0, state_o=0. After release, the sequence timing matches the first scenario.
- 256 forced RUN→WAIT_LINK drops → link_drops_o reads 255 and holds at 255.

Source files
------------

// File: rtl/phy_link_seq_pkg.sv
// Shared types for the PHY bring-up / link supervision controller.
package phy_link_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    SETTLE    = 2'd1,
    WAIT_LINK = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [7:0] LINK_DROPS_MAX = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phy_link_seq_sync.sv
// Two-flop synchronizer for an asynchronous level; 2 clk edges latency, no backpressure.
// Both flops reset to INIT so the synchronized level is known while rst_n is low.
module sync_ff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/phy_link_seq.sv
// PHY reset/settle sequencing and debounced link qualification gating the rx datapath.
// Outputs registered from next state (change with state_o); no backpressure.
module phy_link_seq
  import phy_link_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC = 1000,
  parameter int SETTLE_CYC   = 5000,
  parameter int STABLE_CYC   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_async,
  input  logic       restart_i,
  output logic       phy_rst_n_o,
  output logic       rx_en_o,
  output logic       link_up_o,
  output logic [7:0] link_drops_o,
  output logic [1:0] state_o
);

  localparam int CNT_W = $clog2(max3(RST_HOLD_CYC, SETTLE_CYC, STABLE_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_N    = CNT_W'(STABLE_CYC);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [7:0]       drops, drops_nxt;
  logic             phy_rst_n_nxt, run_nxt, run_q, phy_rst_n_q;
  logic             link_sync;

  sync_ff #(.INIT(1'b0)) u_link_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (link_async),
    .q     (link_sync)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      cnt         <= '0;
      drops       <= '0;
      phy_rst_n_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      drops       <= drops_nxt;
      phy_rst_n_q <= phy_rst_n_nxt;
      run_q       <= run_nxt;
    end
  end

  // One counter serves every state; it is cleared on each transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drops_nxt = drops;
    if (restart_i) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = WAIT_LINK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        WAIT_LINK: begin
          if (!link_sync) begin
            cnt_nxt = '0;
          end else if (cnt_inc == STABLE_N) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        RUN: begin
          if (link_sync) begin
            cnt_nxt = '0;
          end else if (cnt_inc == STABLE_N) begin
            state_nxt = WAIT_LINK;
            cnt_nxt   = '0;
            if (drops != LINK_DROPS_MAX) drops_nxt = drops + 8'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    phy_rst_n_nxt = (state_nxt != HOLD);
    run_nxt       = (state_nxt == RUN);
  end

  assign phy_rst_n_o  = phy_rst_n_q;
  assign rx_en_o      = run_q;
  assign link_up_o    = run_q;
  assign link_drops_o = drops;
  assign state_o      = state;

endmodule
